// File: rtl/priority_drain_encoder.sv
// priority_drain_encoder
// Captures a request vector and hands out the index of every set bit, one per
// valid/ready handshake, in priority order (highest index first by default,
// lowest index first with LSB_FIRST=1). Each emitted bit is cleared from the
// pending register until the vector is exhausted, then the block accepts the
// next vector. Index, last flag and remaining count are decoded from the
// registered pending bits only, so they stay stable while the consumer stalls.
module priority_drain_encoder #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W:0]   count,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;

    // Decoded view of the pending register
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_mask;
    logic [IDX_W:0]   pop;

    // Number of bits still waiting to be emitted
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + (IDX_W+1)'(pending[i]);
        end
    end

    // Winning index: the scan runs towards the preferred end so the last hit wins
    always_comb begin
        sel_idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    sel_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) begin
                    sel_idx = IDX_W'(i);
                end
            end
        end
        sel_mask = WIDTH'(1) << sel_idx;
    end

    // Next state, next pending value and all handshake-side outputs
    always_comb begin
        state_next   = state;
        pending_next = pending;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_idx      = '0;
        out_last     = 1'b0;
        count        = '0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // An all-zero vector is swallowed here and never reaches DRAIN
                    pending_next = in_vec;
                    if (in_vec != '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_idx   = sel_idx;
                count     = pop;
                out_last  = (pop == (IDX_W+1)'(1));
                if (out_ready) begin
                    pending_next = pending & ~sel_mask;
                    if (pop == (IDX_W+1)'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase

        // Abort wins over both a simultaneous accept and a simultaneous handshake
        if (flush) begin
            pending_next = '0;
            state_next   = IDLE;
        end
    end

    // State and pending register; reset clears both without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_priority_drain_encoder.sv
// tb_priority_drain_encoder
// Drives two encoder instances (8-bit MSB-first, 16-bit LSB-first) and checks
// every cycle against a list-of-set-indices model of the request vector.
module tb_priority_drain_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    // Instance A: WIDTH=8, highest index first
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_vec = '0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [2:0] a_out_idx;
    logic       a_out_last;
    logic [3:0] a_count;
    logic       a_busy;

    // Instance B: WIDTH=16, lowest index first
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_vec = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [3:0]  b_out_idx;
    logic        b_out_last;
    logic [4:0]  b_count;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    priority_drain_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_last(a_out_last), .count(a_count), .busy(a_busy)
    );

    priority_drain_encoder #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_last(b_out_last), .count(b_count), .busy(b_busy)
    );

    // Reference: ordered list of the set bit positions in service order
    function automatic void build_expected(input logic [63:0] vec, input int width, input bit lsb_first);
        exp_q.delete();
        if (lsb_first) begin
            for (int i = 0; i < width; i++) if (vec[i]) exp_q.push_back(i);
        end else begin
            for (int i = width - 1; i >= 0; i--) if (vec[i]) exp_q.push_back(i);
        end
    endfunction

    // Send one vector to A and drain it; stall_first forces initial stalls, rand_ready randomises ready
    task automatic drain_a(input logic [7:0] vec, input int stall_first, input bit rand_ready, input string tag);
        logic [10:0] got, want;
        int cyc = 0;
        int stalls = stall_first;
        a_in_vec = vec;
        a_in_valid = 1'b1;
        a_out_ready = 1'b0;
        #1;
        got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
        want = 11'b0_000_0_0000_0_1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_pre_accept got=%b want=%b", tag, got, want);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_vec = 8'($urandom);
        build_expected({56'd0, vec}, 8, 1'b0);
        while (exp_q.size() > 0 && cyc < 100) begin
            if (stalls > 0) begin
                a_out_ready = 1'b0;
                stalls--;
            end else if (rand_ready) begin
                a_out_ready = 1'($urandom_range(0, 1));
            end else begin
                a_out_ready = 1'b1;
            end
            @(negedge clk);
            got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
            want = {1'b1, 3'(exp_q[0]), (exp_q.size() == 1), 4'(exp_q.size()), 1'b1, 1'b0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s_drain vec=%h cyc=%0d got=%b want=%b", tag, vec, cyc, got, want);
            end
            @(posedge clk); #1;
            if (a_out_ready) void'(exp_q.pop_front());
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout got=%0d cycles want=<100", tag, cyc);
        end
        a_out_ready = 1'b0;
        @(negedge clk);
        got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
        want = 11'b0_000_0_0000_0_1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_post_idle vec=%h got=%b want=%b", tag, vec, got, want);
        end
    endtask

    // Same flow for instance B
    task automatic drain_b(input logic [15:0] vec, input bit rand_ready, input string tag);
        logic [12:0] got, want;
        int cyc = 0;
        b_in_vec = vec;
        b_in_valid = 1'b1;
        b_out_ready = 1'b0;
        #1;
        got = {b_out_valid, b_out_idx, b_out_last, b_count, b_busy, b_in_ready};
        want = 13'b0_0000_0_00000_0_1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_pre_accept got=%b want=%b", tag, got, want);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_vec = 16'($urandom);
        build_expected({48'd0, vec}, 16, 1'b1);
        while (exp_q.size() > 0 && cyc < 100) begin
            b_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            got = {b_out_valid, b_out_idx, b_out_last, b_count, b_busy, b_in_ready};
            want = {1'b1, 4'(exp_q[0]), (exp_q.size() == 1), 5'(exp_q.size()), 1'b1, 1'b0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s_drain vec=%h cyc=%0d got=%b want=%b", tag, vec, cyc, got, want);
            end
            @(posedge clk); #1;
            if (b_out_ready) void'(exp_q.pop_front());
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout got=%0d cycles want=<100", tag, cyc);
        end
        b_out_ready = 1'b0;
        @(negedge clk);
        got = {b_out_valid, b_out_idx, b_out_last, b_count, b_busy, b_in_ready};
        want = 13'b0_0000_0_00000_0_1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_post_idle vec=%h got=%b want=%b", tag, vec, got, want);
        end
    endtask

    task automatic test_reset();
        logic [10:0] got_a;
        logic [12:0] got_b;
        #1 rst = 1'b1;
        #1;
        got_a = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
        n_checks++;
        if (got_a !== 11'b0_000_0_0000_0_1) begin
            n_fail++;
            $display("FAIL reset_a got=%b want=%b", got_a, 11'b0_000_0_0000_0_1);
        end
        got_b = {b_out_valid, b_out_idx, b_out_last, b_count, b_busy, b_in_ready};
        n_checks++;
        if (got_b !== 13'b0_0000_0_00000_0_1) begin
            n_fail++;
            $display("FAIL reset_b got=%b want=%b", got_b, 13'b0_0000_0_00000_0_1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed();
        drain_a(8'b1010_0101, 0, 1'b0, "pattern_a5");
        drain_a(8'h90, 3, 1'b0, "stall_90");
        drain_a(8'h00, 0, 1'b0, "zero_vec");
        drain_a(8'hFF, 0, 1'b0, "all_ones");
        drain_a(8'h01, 0, 1'b0, "single_bit0");
        drain_a(8'h80, 2, 1'b0, "single_bit7");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drain_a(8'($urandom) | 8'h01, 0, 1'b0, "b2b");
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: v = 8'($urandom) & 8'($urandom);
                1: v = 8'($urandom);
                2: v = 8'h01 << $urandom_range(0, 7);
                default: v = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            endcase
            drain_a(v, int'($urandom_range(0, 2)), 1'b1, "rand_a");
        end
    endtask

    task automatic test_lsb_first();
        drain_b(16'h8005, 1'b0, "lsb_8005");
        drain_b(16'hFFFF, 1'b0, "lsb_ffff");
        drain_b(16'h0000, 1'b0, "lsb_zero");
        for (int i = 0; i < 12; i++) drain_b(16'($urandom) & 16'($urandom), 1'b1, "lsb_rand");
    endtask

    task automatic test_flush();
        logic [10:0] got, want;
        a_in_vec = 8'hFF;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_out_ready = 1'b1;
            flush = (k == 2);
            @(negedge clk);
            got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
            want = {1'b1, 3'(7 - k), 1'b0, 4'(8 - k), 1'b1, 1'b0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL flush_drain k=%0d got=%b want=%b", k, got, want);
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        // Flush coincident with an accept: the vector must not be captured
        a_in_vec = 8'h0F;
        a_in_valid = 1'b1;
        flush = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
            want = 11'b0_000_0_0000_0_1;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL flush_idle k=%0d got=%b want=%b", k, got, want);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            a_in_valid = 1'b0;
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        logic [10:0] got, want;
        a_in_vec = 8'hFF;
        a_in_valid = 1'b1;
        a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre got=%b want=1", a_out_valid);
        end
        #2 rst = 1'b1;
        #1;
        got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
        want = 11'b0_000_0_0000_0_1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b want=%b", got, want);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        got = {a_out_valid, a_out_idx, a_out_last, a_count, a_busy, a_in_ready};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL rstmid_after got=%b want=%b", got, want);
        end
        a_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_lsb_first();
        test_flush();
        test_reset_mid_drain();
        test_random();
        drain_a(8'b1010_0101, 0, 1'b0, "final_a5");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
